seq_match_counter: RTL and testbench
====================================

# seq_match_counter

- Windowed event counter that sits directly downstream of the serial pattern detector.
- Consumes the detector's single-cycle match pulse and counts pulses over a programmable window of clock cycles.
- Presents the final count to a register or bus reader through a valid/ready handshake.
- Turns raw match strobes into a rate measurement that firmware can read.

## Interface
Parameters:
- CNT_W, default 8: width of the match count.
- WIN_W, default 16: width of the window length.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- start  input  1  single-cycle request to open a counting window; honoured only in IDLE.
- win_len  input  WIN_W  window length in cycles; sampled when start is honoured.
- match_in  input  1  match pulse from the pattern detector; one count per cycle it is high.
- busy  output  1  high in COUNT and REPORT.
- cnt_valid  output  1  result available.
- cnt_ready  input  1  reader accepts the result.
- cnt_data  output  CNT_W  final match count.
- cnt_ovf  output  1  count saturated during the window.
- thresh  input  CNT_W  IRQ threshold; present only with SEQ_CNT_IRQ_EN.
- irq_clr  input  1  clears irq; present only with SEQ_CNT_IRQ_EN.
- irq  output  1  sticky threshold interrupt; present only with SEQ_CNT_IRQ_EN.

## Operation
Reset values: every output 0 and state IDLE.

FSM states IDLE, COUNT, REPORT:
- **IDLE**
  - start=1 with win_len≠0 → COUNT. Load timer=win_len and clear the internal count and ovf.
  - start=1 with win_len=0 → ignored; stay in IDLE.
  - match_in is ignored.
- **COUNT**
  - Each cycle, match_in=1 increments the count. The count saturates at 2^CNT_W−1.
  - An increment attempted at the maximum sets ovf; ovf stays set until the next window starts.
  - The timer decrements every cycle. In the cycle where timer==1, that cycle's match is included, cnt_data/cnt_ovf are loaded, and the FSM moves to REPORT.
  - start is ignored.
- **REPORT**
  - cnt_valid=1; cnt_data and cnt_ovf stay stable until the handshake.
  - cnt_valid & cnt_ready → IDLE, with cnt_valid low the next cycle.
  - match_in and start are dropped.
- cnt_data and cnt_ovf hold their last value after the handshake, until the next window's load.
- Reset asserted mid-window aborts immediately: no report, and outputs return to reset values.

## Timing
- start high in cycle T → state=COUNT during cycles T+1 … T+N (N=win_len). match_in is sampled in exactly those N cycles.
- cnt_valid is high from cycle T+N+1; all outputs are registered.
- win_len=1: exactly one sample, in cycle T+1.
- Minimum restart spacing: the earliest next honoured start is the cycle after the FSM returns to IDLE, i.e. one cycle after the handshake.
- cnt_ready held high before cnt_valid: the handshake completes in the first REPORT cycle, so REPORT lasts one cycle.

## Configuration
Macro SEQ_CNT_IRQ_EN.

Defined:
- thresh is sampled at start.
- irq is set on the cycle after the running count first equals thresh (thresh≠0) during COUNT.
- irq is sticky across windows.
- irq_clr=1 clears it; if clear and set occur in the same cycle, set wins.
- thresh=0 never fires.

Undefined:
- thresh, irq_clr and irq ports are absent, and there is no threshold logic.
- All other behaviour is unchanged.

## Structure
- Package seq_cnt_pkg holds the state enum (IDLE/COUNT/REPORT) and the default CNT_W/WIN_W constants.
- One sub-module, seq_sat_counter: a parameterised saturating up-counter with clear, increment and overflow-flag outputs. The top contains the FSM, the window timer and the handshake.

## Test plan
- Reset: outputs 0. Then start with win_len=10 and match_in pulses in cycles 2, 6 and 10 of the window → cnt_valid at T+11, cnt_data=3, cnt_ovf=0.
- Window edges: win_len=4, with pulses in the start cycle T and in T+5 (outside the window) plus one in T+4 → cnt_data=1.
- Saturation: CNT_W=4, win_len=20, match_in held high → cnt_data=15, cnt_ovf=1. The next window with no pulses → cnt_data=0, cnt_ovf=0.
- Handshake stall: keep cnt_ready low for 5 cycles with pulses arriving and start asserted during the stall → cnt_data stable and start ignored. Raising cnt_ready → IDLE the next cycle.
- Boundary and reset: start with win_len=0 → busy stays 0. Assert reset 3 cycles into a win_len=8 window → no cnt_valid and all outputs 0.
- SEQ_CNT_IRQ_EN: thresh=2 with 3 pulses → irq rises the cycle after the second pulse and persists past the handshake. irq_clr → irq=0. thresh=0 → irq never asserts.

Source files
------------

// File: rtl/seq_cnt_pkg.sv
// Shared definitions for the windowed match counter.
//   state_t   : FSM encoding (IDLE / COUNT / REPORT)
//   CNT_W_DEF : default width of the match count
//   WIN_W_DEF : default width of the window length
package seq_cnt_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    localparam int CNT_W_DEF = 8;
    localparam int WIN_W_DEF = 16;

endpackage

// File: rtl/seq_match_counter_if.sv
// Result handshake between the match counter and its reader.
//   cnt_valid : result available (driven by the counter)
//   cnt_ready : reader accepts the result (driven by the reader)
//   cnt_data  : final match count of the window
//   cnt_ovf   : the count saturated during the window
// Modports: master = counter side, slave = reader side.
interface seq_match_counter_if
    import seq_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             cnt_valid;
    logic             cnt_ready;
    logic [CNT_W-1:0] cnt_data;
    logic             cnt_ovf;

    modport master (
        output cnt_valid,
        output cnt_data,
        output cnt_ovf,
        input  cnt_ready
    );

    modport slave (
        input  cnt_valid,
        input  cnt_data,
        input  cnt_ovf,
        output cnt_ready
    );

endinterface

// File: rtl/seq_sat_counter.sv
// Saturating up-counter with synchronous clear and sticky overflow flag.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   clr        : clears the stored count and overflow flag
//   inc        : add one this cycle (saturates at 2^W-1)
//   count      : count including this cycle's increment (combinational look-ahead)
//   ovf        : overflow flag including this cycle's increment attempt
// The outputs show the value the counter will hold after this edge, so the
// owner can capture a result that already includes the current cycle.
module seq_sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count,
    output logic         ovf
);

    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;
    logic         ovf_q;

    always_comb begin
        count = count_q;
        ovf   = ovf_q;
        if (inc) begin
            if (count_q == MAX) begin
                ovf = 1'b1;
            end else begin
                count = count_q + W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else if (clr) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count;
            ovf_q   <= ovf;
        end
    end

endmodule

// File: rtl/seq_match_counter.sv
// Windowed event counter behind the serial pattern detector. Counts
// single-cycle match pulses over a programmable number of cycles and hands
// the result to a reader over a valid/ready handshake.
// Ports:
//   clk, reset : clock, asynchronous active-high reset
//   start      : open a window (honoured only when idle and win_len != 0)
//   win_len    : window length in cycles, sampled at start
//   match_in   : match pulse, one count per high cycle inside the window
//   busy       : high while counting or reporting
//   cnt        : result handshake (master side)
//   thresh     : IRQ threshold, sampled at start        (SEQ_CNT_IRQ_EN only)
//   irq_clr    : clears irq                              (SEQ_CNT_IRQ_EN only)
//   irq        : sticky threshold interrupt              (SEQ_CNT_IRQ_EN only)
// Optional feature macro: SEQ_CNT_IRQ_EN (threshold interrupt).
module seq_match_counter
    import seq_cnt_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int WIN_W = WIN_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIN_W-1:0] win_len,
    input  logic             match_in,
    output logic             busy,
`ifdef SEQ_CNT_IRQ_EN
    input  logic [CNT_W-1:0] thresh,
    input  logic             irq_clr,
    output logic             irq,
`endif
    seq_match_counter_if.master cnt
);

    state_t           state;
    state_t           state_nxt;
    logic [WIN_W-1:0] timer;
    logic             win_open;
    logic             win_last;
    logic             inc;
    logic [CNT_W-1:0] count;
    logic             ovf;

    logic             busy_q;
    logic             valid_q;
    logic [CNT_W-1:0] data_q;
    logic             ovf_q;

    assign inc = (state == COUNT) && match_in;

    seq_sat_counter #(
        .W (CNT_W)
    ) u_sat (
        .clk   (clk),
        .reset (reset),
        .clr   (win_open),
        .inc   (inc),
        .count (count),
        .ovf   (ovf)
    );

    always_comb begin
        state_nxt = state;
        win_open  = 1'b0;
        win_last  = 1'b0;
        case (state)
            IDLE: begin
                if (start && (win_len != '0)) begin
                    state_nxt = COUNT;
                    win_open  = 1'b1;
                end
            end
            COUNT: begin
                // Last window cycle: this cycle's match is already in count/ovf.
                if (timer == WIN_W'(1)) begin
                    state_nxt = REPORT;
                    win_last  = 1'b1;
                end
            end
            REPORT: begin
                // cnt_valid is high for the whole of REPORT, so ready alone
                // completes the handshake.
                if (cnt.cnt_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            timer   <= '0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            // Outputs are decoded from the next state so they are registered
            // and line up with the state they describe.
            busy_q  <= (state_nxt != IDLE);
            valid_q <= (state_nxt == REPORT);
            if (win_open) begin
                timer <= win_len;
            end else if (state == COUNT) begin
                timer <= timer - WIN_W'(1);
            end
            if (win_last) begin
                data_q <= count;
                ovf_q  <= ovf;
            end
        end
    end

    assign busy          = busy_q;
    assign cnt.cnt_valid = valid_q;
    assign cnt.cnt_data  = data_q;
    assign cnt.cnt_ovf   = ovf_q;

`ifdef SEQ_CNT_IRQ_EN
    logic [CNT_W-1:0] thresh_q;
    logic             irq_q;
    logic             irq_set;

    // count is the post-increment value; !ovf excludes repeated increments
    // while parked at the maximum, so this fires only on first arrival.
    assign irq_set = inc && (thresh_q != '0) && (count == thresh_q) && !ovf;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            thresh_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (win_open) begin
                thresh_q <= thresh;
            end
            if (irq_set) begin
                irq_q <= 1'b1;
            end else if (irq_clr) begin
                irq_q <= 1'b0;
            end
        end
    end

    assign irq = irq_q;
`endif

endmodule

// File: tb/tb_seq_match_counter.sv
// Directed bench for seq_match_counter (built with CNT_W=4 so saturation is
// reachable in a short window). Expected results are queued when a window is
// opened and compared when the DUT raises cnt_valid.
module tb_seq_match_counter;

    localparam int CW = 4;
    localparam int WW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [WW-1:0] win_len;
    logic          match_in;
    logic          busy;
`ifdef SEQ_CNT_IRQ_EN
    logic [CW-1:0] thresh;
    logic          irq_clr;
    logic          irq;
`endif

    seq_match_counter_if #(.CNT_W(CW)) cnt_if ();

    seq_match_counter #(
        .CNT_W (CW),
        .WIN_W (WW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .win_len  (win_len),
        .match_in (match_in),
        .busy     (busy),
`ifdef SEQ_CNT_IRQ_EN
        .thresh   (thresh),
        .irq_clr  (irq_clr),
        .irq      (irq),
`endif
        .cnt      (cnt_if)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [CW-1:0] data;
        logic          ovf;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Drive start in the current cycle T and advance to T+1.
    task automatic open_window(input int n, input logic m0, input logic [CW-1:0] ed, input logic eo);
        sb.push_back('{data: ed, ovf: eo});
        win_len  = WW'(n);
        start    = 1'b1;
        match_in = m0;
        tick();
        start    = 1'b0;
        match_in = 1'b0;
    endtask

    // Called in cycle T+N+1: result must be valid now. Optionally stalls the
    // reader with pulses and start requests before completing the handshake.
    task automatic finish_window(input int stall);
        exp_t e;
        int   waited;
        check("valid_latency", cnt_if.cnt_valid, 1'b1);
        waited = 0;
        while (!cnt_if.cnt_valid && waited < 8) begin
            tick();
            waited++;
        end
        if (!cnt_if.cnt_valid) begin
            check("valid_timeout", 1'b0, 1'b1);
        end
        if (sb.size() == 0) begin
            check("sb_empty", 1'b1, 1'b0);
            e = '0;
        end else begin
            e = sb.pop_front();
        end
        check("cnt_data", cnt_if.cnt_data, e.data);
        check("cnt_ovf", cnt_if.cnt_ovf, e.ovf);
        for (int s = 0; s < stall; s++) begin
            match_in = 1'b1;
            start    = 1'b1;
            win_len  = WW'(5);
            tick();
            check("stall_valid", cnt_if.cnt_valid, 1'b1);
            check("stall_data", cnt_if.cnt_data, e.data);
            check("stall_busy", busy, 1'b1);
        end
        start           = 1'b0;
        match_in        = 1'b0;
        cnt_if.cnt_ready = 1'b1;
        tick();
        cnt_if.cnt_ready = 1'b0;
        check("valid_drop", cnt_if.cnt_valid, 1'b0);
        check("busy_idle", busy, 1'b0);
        check("data_hold", cnt_if.cnt_data, e.data);
    endtask

    task automatic run_window(input int n, input logic [63:0] pm, input logic [CW-1:0] ed,
                              input logic eo, input int stall);
        open_window(n, pm[0], ed, eo);
        for (int k = 1; k <= n; k++) begin
            match_in = pm[k];
            if (k == 1) check("busy_count", busy, 1'b1);
            if (k == n) check("valid_early", cnt_if.cnt_valid, 1'b0);
            tick();
        end
        match_in = pm[n+1];
        finish_window(stall);
    endtask

    initial begin
        logic [63:0] m;
        bit          seen;

        reset            = 1'b1;
        start            = 1'b0;
        win_len          = '0;
        match_in         = 1'b0;
        cnt_if.cnt_ready = 1'b0;
`ifdef SEQ_CNT_IRQ_EN
        thresh  = '0;
        irq_clr = 1'b0;
`endif
        tick();
        tick();
        check("rst_busy", busy, 1'b0);
        check("rst_valid", cnt_if.cnt_valid, 1'b0);
        check("rst_data", cnt_if.cnt_data, 0);
        check("rst_ovf", cnt_if.cnt_ovf, 1'b0);
`ifdef SEQ_CNT_IRQ_EN
        check("rst_irq", irq, 1'b0);
`endif
        reset = 1'b0;
        tick();

        // Pulses in window cycles 2, 6 and 10.
        m = '0; m[2] = 1'b1; m[6] = 1'b1; m[10] = 1'b1;
        run_window(10, m, 4'd3, 1'b0, 0);

        // Window edges: start cycle and post-window pulses are not counted.
        m = '0; m[0] = 1'b1; m[4] = 1'b1; m[5] = 1'b1;
        run_window(4, m, 4'd1, 1'b0, 0);

        // Saturation, then a clean window clears count and overflow.
        m = '0;
        for (int k = 1; k <= 20; k++) m[k] = 1'b1;
        run_window(20, m, 4'd15, 1'b1, 0);
        run_window(6, 64'd0, 4'd0, 1'b0, 0);

        // win_len = 1: only cycle T+1 is sampled.
        m = '0; m[0] = 1'b1; m[1] = 1'b1; m[2] = 1'b1;
        run_window(1, m, 4'd1, 1'b0, 0);

        // Reader stall with pulses and start requests arriving meanwhile.
        m = '0; m[1] = 1'b1;
        run_window(3, m, 4'd1, 1'b0, 5);
        tick();
        check("stall_start_ignored", busy, 1'b0);

        // Zero-length window is ignored.
        win_len = '0;
        start   = 1'b1;
        tick();
        start = 1'b0;
        check("zero_len_busy", busy, 1'b0);
        tick();
        check("zero_len_busy2", busy, 1'b0);
        check("zero_len_valid", cnt_if.cnt_valid, 1'b0);

        // Reset three cycles into an 8-cycle window.
        win_len  = WW'(8);
        start    = 1'b1;
        tick();
        start    = 1'b0;
        match_in = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_valid", cnt_if.cnt_valid, 1'b0);
        check("abort_data", cnt_if.cnt_data, 0);
        check("abort_ovf", cnt_if.cnt_ovf, 1'b0);
        tick();
        reset    = 1'b0;
        match_in = 1'b0;
        seen     = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (cnt_if.cnt_valid || busy) seen = 1'b1;
        end
        check("abort_no_report", seen, 1'b0);

        // Recovery after the abort.
        m = '0; m[1] = 1'b1; m[2] = 1'b1;
        run_window(2, m, 4'd2, 1'b0, 0);

`ifdef SEQ_CNT_IRQ_EN
        // thresh = 2 with pulses in window cycles 1, 3, 5.
        thresh = 4'd2;
        open_window(6, 1'b0, 4'd3, 1'b0);
        thresh = 4'd0;
        for (int k = 1; k <= 6; k++) begin
            match_in = (k == 1 || k == 3 || k == 5);
            if (k == 3) check("irq_before", irq, 1'b0);
            if (k == 4) check("irq_rise", irq, 1'b1);
            tick();
        end
        match_in = 1'b0;
        finish_window(0);
        check("irq_sticky", irq, 1'b1);
        irq_clr = 1'b1;
        tick();
        irq_clr = 1'b0;
        check("irq_clr", irq, 1'b0);

        // thresh = 0 never fires.
        thresh = 4'd0;
        open_window(4, 1'b0, 4'd3, 1'b0);
        seen = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            match_in = (k <= 3);
            tick();
            if (irq) seen = 1'b1;
        end
        match_in = 1'b0;
        finish_window(0);
        check("irq_thresh0", seen | irq, 1'b0);
`endif

        check("sb_drained", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
